// File: rtl/serial_memory_loader.sv
// Byte-stream command engine: parses P/G/W/R packets from a UART receiver, drives the
// processor's external memory port and run control, and returns ack/NAK or read data.
module serial_memory_loader #(
  parameter logic [2:0] WRITE_WORD_MODE  = 3'd3,
  parameter logic [2:0] READ_WORD_MODE   = 3'd3,
  parameter int         MEM_READ_LATENCY = 1,
  parameter int         TIMEOUT_CYCLES   = 1000000,
  parameter logic       RUN_AT_RESET     = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [31:0] mem_rdata,
  output logic        proc_run,
  output logic        ext_mem_control,
  output logic [31:0] ext_address,
  output logic [31:0] ext_data,
  output logic [2:0]  ext_read_mode,
  output logic [2:0]  ext_write_mode,
  output logic        busy
);

  localparam int            TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]    LAT_LAST  = 3'(MEM_READ_LATENCY - 1);

  localparam logic [7:0] OP_PAUSE = 8'h50;
  localparam logic [7:0] OP_RUN   = 8'h47;
  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] ACK      = 8'h06;
  localparam logic [7:0] NAK      = 8'h15;

  typedef enum logic [2:0] {IDLE, ADDR, DATA, WRITE, READ_WAIT, SEND, RESP} state_t;

  state_t        state;
  logic          isWrite;
  logic [1:0]    byteCnt;
  logic [31:0]   addrShift;
  logic [31:0]   dataShift;
  logic [31:0]   rdataShift;
  logic [2:0]    latCnt;
  logic [TW-1:0] idleCnt;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      isWrite         <= 1'b0;
      byteCnt         <= 2'd0;
      addrShift       <= 32'd0;
      dataShift       <= 32'd0;
      rdataShift      <= 32'd0;
      latCnt          <= 3'd0;
      idleCnt         <= '0;
      proc_run        <= RUN_AT_RESET;
      ext_mem_control <= 1'b0;
      ext_address     <= 32'd0;
      ext_data        <= 32'd0;
      ext_read_mode   <= 3'd0;
      ext_write_mode  <= 3'd0;
      tx_valid        <= 1'b0;
      tx_data         <= 8'd0;
    end else begin
      case (state)
        IDLE: if (rx_valid) begin
          case (rx_data)
            OP_PAUSE: begin proc_run <= 1'b0; state <= RESP; tx_valid <= 1'b1; tx_data <= ACK; end
            OP_RUN:   begin proc_run <= 1'b1; state <= RESP; tx_valid <= 1'b1; tx_data <= ACK; end
            OP_WRITE, OP_READ: begin
              isWrite <= (rx_data == OP_WRITE);
              byteCnt <= 2'd0;
              idleCnt <= '0;
              state   <= ADDR;
            end
            default:  begin state <= RESP; tx_valid <= 1'b1; tx_data <= NAK; end
          endcase
        end

        ADDR: if (rx_valid) begin
          idleCnt   <= '0;
          byteCnt   <= byteCnt + 2'd1;
          addrShift <= {addrShift[23:0], rx_data};
          if (byteCnt == 2'd3) begin
            if (isWrite) state <= DATA;
            else if (proc_run) begin
              state <= RESP; tx_valid <= 1'b1; tx_data <= NAK;
            end else begin
              ext_address     <= {addrShift[23:0], rx_data};
              ext_mem_control <= 1'b1;
              ext_read_mode   <= READ_WORD_MODE;
              latCnt          <= 3'd0;
              state           <= READ_WAIT;
            end
          end
        end else if (idleCnt == IDLE_LAST) state <= IDLE;
        else idleCnt <= idleCnt + TW'(1);

        DATA: if (rx_valid) begin
          idleCnt   <= '0;
          byteCnt   <= byteCnt + 2'd1;
          dataShift <= {dataShift[23:0], rx_data};
          if (byteCnt == 2'd3) begin
            if (proc_run) begin
              state <= RESP; tx_valid <= 1'b1; tx_data <= NAK;
            end else begin
              ext_address     <= addrShift;
              ext_data        <= {dataShift[23:0], rx_data};
              ext_mem_control <= 1'b1;
              ext_write_mode  <= WRITE_WORD_MODE;
              state           <= WRITE;
            end
          end
        end else if (idleCnt == IDLE_LAST) state <= IDLE;
        else idleCnt <= idleCnt + TW'(1);

        // Single-cycle store strobe
        WRITE: begin
          ext_mem_control <= 1'b0;
          ext_write_mode  <= 3'd0;
          state           <= RESP;
          tx_valid        <= 1'b1;
          tx_data         <= ACK;
        end

        READ_WAIT: if (latCnt == LAT_LAST) begin
          rdataShift      <= mem_rdata;
          tx_data         <= mem_rdata[31:24];
          tx_valid        <= 1'b1;
          byteCnt         <= 2'd3;
          ext_mem_control <= 1'b0;
          ext_read_mode   <= 3'd0;
          state           <= SEND;
        end else latCnt <= latCnt + 3'd1;

        // rdataShift keeps the byte on air in its top lane; shifting exposes the next one
        SEND: if (tx_ready) begin
          if (byteCnt == 2'd0) begin
            tx_valid <= 1'b0;
            state    <= IDLE;
          end else begin
            byteCnt    <= byteCnt - 2'd1;
            tx_data    <= rdataShift[23:16];
            rdataShift <= {rdataShift[23:0], 8'h00};
          end
        end

        RESP: if (tx_ready) begin
          tx_valid <= 1'b0;
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_memory_loader.sv
// Randomized packet stream against a packet-level reference model (run flag + word memory),
// plus directed latency, stall, timeout and reset cases.
module tb_serial_memory_loader;
  localparam int LAT = 2;
  localparam int TMO = 100;

  logic        clk = 1'b0, rst = 1'b0;
  logic [7:0]  rx_data = 8'd0, tx_data;
  logic        rx_valid = 1'b0, tx_valid, tx_ready = 1'b0;
  logic [31:0] memRdata = 32'h0BAD0BAD;
  logic        proc_run, ext_mem_control, busy;
  logic [31:0] ext_address, ext_data;
  logic [2:0]  ext_read_mode, ext_write_mode;

  always #5 clk = ~clk;

  serial_memory_loader #(
    .WRITE_WORD_MODE(3'd3), .READ_WORD_MODE(3'd3), .MEM_READ_LATENCY(LAT),
    .TIMEOUT_CYCLES(TMO), .RUN_AT_RESET(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .mem_rdata(memRdata),
    .proc_run(proc_run), .ext_mem_control(ext_mem_control), .ext_address(ext_address),
    .ext_data(ext_data), .ext_read_mode(ext_read_mode), .ext_write_mode(ext_write_mode),
    .busy(busy)
  );

  int nChecks = 0, nPass = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    nChecks++;
    if (got === want) nPass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, want);
  endtask

  function automatic logic [31:0] memDefault(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h12345678;
  endfunction

  // Processor memory environment: data valid only on the LAT-th cycle of a read
  logic [31:0] envMem [logic [31:0]];
  int          wrCount = 0, rdSeen = 0, lastRdLen = 0;
  logic [31:0] lastWrAddr = 0, lastWrData = 0;
  always @(negedge clk) begin
    if (ext_mem_control && ext_write_mode == 3'd3) begin
      wrCount++; lastWrAddr = ext_address; lastWrData = ext_data;
      envMem[ext_address] = ext_data;
    end
    if (ext_mem_control && ext_read_mode == 3'd3) begin
      rdSeen++;
      memRdata = (rdSeen == LAT) ?
        (envMem.exists(ext_address) ? envMem[ext_address] : memDefault(ext_address)) : 32'h0BAD0BAD;
    end else begin
      if (rdSeen != 0) lastRdLen = rdSeen;
      rdSeen = 0;
      memRdata = 32'h0BAD0BAD;
    end
  end

  // Reference model state
  logic        refRun = 1'b0;
  logic [31:0] refMem [logic [31:0]];
  int          expWr = 0;

  task automatic sendByte(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic getByte(input logic [7:0] want, input int stall, input string tag);
    int t = 0;
    while (!tx_valid && t < 50) begin @(negedge clk); t++; end
    chk({tag, "_valid"}, tx_valid, 1);
    if (!tx_valid) return;
    chk(tag, tx_data, want);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk({tag, "_hold"}, {tx_valid, tx_data}, {1'b1, want});
    end
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
  endtask

  task automatic doPacket(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d,
                          input int gap, input int stall);
    logic [7:0]  resp [$];
    logic [31:0] rd;
    case (op)
      8'h50: begin refRun = 1'b0; resp.push_back(8'h06); end
      8'h47: begin refRun = 1'b1; resp.push_back(8'h06); end
      8'h57: if (refRun) resp.push_back(8'h15);
             else begin refMem[a] = d; expWr++; resp.push_back(8'h06); end
      8'h52: if (refRun) resp.push_back(8'h15);
             else begin
               rd = refMem.exists(a) ? refMem[a] : memDefault(a);
               for (int i = 0; i < 4; i++) resp.push_back(8'(rd >> (24 - 8 * i)));
             end
      default: resp.push_back(8'h15);
    endcase
    sendByte(op);
    if (op == 8'h57 || op == 8'h52)
      for (int i = 0; i < 4; i++) begin repeat (gap) @(negedge clk); sendByte(8'(a >> (24 - 8 * i))); end
    if (op == 8'h57)
      for (int i = 0; i < 4; i++) begin repeat (gap) @(negedge clk); sendByte(8'(d >> (24 - 8 * i))); end
    foreach (resp[i]) getByte(resp[i], stall, $sformatf("op%0h_b%0d", op, i));
    chk("txDrop", tx_valid, 0);
    chk("idleAfter", busy, 0);
    chk("procRun", proc_run, refRun);
    chk("wrCount", wrCount, expWr);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] pkt [$];
    logic [7:0] op;
    int r;

    repeat (3) @(negedge clk);
    chk("rstRun", proc_run, 0);          chk("rstMemCtl", ext_mem_control, 0);
    chk("rstAddr", ext_address, 0);      chk("rstData", ext_data, 0);
    chk("rstRdMode", ext_read_mode, 0);  chk("rstWrMode", ext_write_mode, 0);
    chk("rstTxValid", tx_valid, 0);      chk("rstTxData", tx_data, 0);
    chk("rstBusy", busy, 0);
    rst = 1'b1;
    @(negedge clk);

    // Run / pause take effect the cycle after the opcode
    sendByte(8'h47); chk("runNext", proc_run, 1); getByte(8'h06, 1, "runAck"); refRun = 1'b1;
    sendByte(8'h50); chk("pauseNext", proc_run, 0); getByte(8'h06, 0, "pauseAck"); refRun = 1'b0;

    // Write: strobe the cycle after the last byte, ack the cycle after that
    pkt = '{8'h57, 8'h00, 8'h00, 8'h00, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    foreach (pkt[i]) sendByte(pkt[i]);
    chk("wrStrobe", ext_mem_control, 1); chk("wrAddr", ext_address, 32'h10);
    chk("wrData", ext_data, 32'hDEADBEEF); chk("wrMode", ext_write_mode, 3);
    @(negedge clk);
    chk("wrStrobeEnd", ext_mem_control, 0); chk("wrModeEnd", ext_write_mode, 0);
    chk("wrAckLat", tx_valid, 1);
    refMem[32'h10] = 32'hDEADBEEF; expWr++;
    getByte(8'h06, 0, "wrAck");
    chk("wrCount", wrCount, expWr);

    // Reads with 3-cycle stalls between bytes
    envMem[32'h20] = 32'hCAFEF00D; refMem[32'h20] = 32'hCAFEF00D;
    doPacket(8'h52, 32'h20, 0, 0, 3);
    chk("rdModeLen", lastRdLen, LAT);
    doPacket(8'h52, 32'h10, 0, 1, 3);

    // Running: accesses rejected, unknown opcode rejected
    doPacket(8'h47, 0, 0, 0, 0);
    doPacket(8'h57, 32'h30, 32'h11112222, 0, 0);
    doPacket(8'h41, 0, 0, 0, 0);
    doPacket(8'h52, 32'h10, 0, 0, 0);
    // A byte arriving while a response is pending is dropped
    sendByte(8'h41); sendByte(8'h50);
    getByte(8'h15, 1, "dropNak");
    chk("dropRun", proc_run, 1);
    chk("dropIdle", busy, 0);
    doPacket(8'h50, 0, 0, 0, 0);

    // Timeout: 100 idle cycles discard the partial packet
    sendByte(8'h57); sendByte(8'h00); sendByte(8'h00);
    repeat (TMO - 1) @(negedge clk);
    chk("tmoBefore", busy, 1);
    @(negedge clk);
    chk("tmoIdle", busy, 0); chk("tmoNoTx", tx_valid, 0); chk("tmoNoWr", wrCount, expWr);
    doPacket(8'h52, 32'h10, 0, 0, 1);

    // A byte landing on the expiry cycle is accepted
    sendByte(8'h57); sendByte(8'h00); sendByte(8'h00);
    repeat (TMO - 1) @(negedge clk);
    pkt = '{8'h00, 8'h40, 8'h01, 8'h23, 8'h45, 8'h67};
    foreach (pkt[i]) sendByte(pkt[i]);
    refMem[32'h40] = 32'h01234567; expWr++;
    getByte(8'h06, 0, "edgeAck");
    chk("edgeWrCount", wrCount, expWr); chk("edgeWrAddr", lastWrAddr, 32'h40);
    chk("edgeWrData", lastWrData, 32'h01234567);

    // Randomized packet stream
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 9:    op = 8'h50;
        1:       op = 8'h47;
        2, 3, 4: op = 8'h57;
        5, 6, 7: op = 8'h52;
        default: begin
          op = 8'($urandom);
          while (op == 8'h50 || op == 8'h47 || op == 8'h57 || op == 8'h52) op = 8'($urandom);
        end
      endcase
      doPacket(op, 32'($urandom_range(0, 7)) * 4, $urandom,
               $urandom_range(0, 3), $urandom_range(0, 2));
    end

    // Reset while the third read byte is on air
    doPacket(8'h50, 0, 0, 0, 0);
    sendByte(8'h52); sendByte(8'h00); sendByte(8'h00); sendByte(8'h00); sendByte(8'h20);
    getByte(refMem[32'h20][31:24], 0, "rstB0");
    getByte(refMem[32'h20][23:16], 0, "rstB1");
    chk("rstB2Valid", tx_valid, 1);
    #2 rst = 1'b0;
    #1;
    chk("midRstTxValid", tx_valid, 0); chk("midRstBusy", busy, 0);
    chk("midRstRun", proc_run, 0);     chk("midRstMemCtl", ext_mem_control, 0);
    @(negedge clk);
    rst = 1'b1; refRun = 1'b0;
    @(negedge clk);
    doPacket(8'h52, 32'h20, 0, 0, 1);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
